// File: rtl/fade_ramp_pkg.sv
`default_nettype none
// ============================================================================
// fade_ramp_pkg : phase encodings shared by the fade ramp slice
// Rev 1.0
// ============================================================================
package fade_ramp_pkg;

    localparam int PHASE_W = 3;

    localparam logic [PHASE_W-1:0] FADE_IDLE    = 3'd0;
    localparam logic [PHASE_W-1:0] FADE_UP      = 3'd1;
    localparam logic [PHASE_W-1:0] FADE_HOLD_HI = 3'd2;
    localparam logic [PHASE_W-1:0] FADE_DOWN    = 3'd3;
    localparam logic [PHASE_W-1:0] FADE_HOLD_LO = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fade_ramp_if.sv
`default_nettype none
// ============================================================================
// fade_ramp_if : configuration, step and duty-output bundle of fade_ramp
// Rev 1.0
// ============================================================================
interface fade_ramp_if #(
    parameter int WIDTH  = 8,
    parameter int HOLD_W = 8
);
    import fade_ramp_pkg::*;

    logic                enable;
    logic                tick;
    logic [WIDTH-1:0]    min_level;
    logic [WIDTH-1:0]    max_level;
    logic [WIDTH-1:0]    step;
    logic [HOLD_W-1:0]   hold_ticks;
    logic [WIDTH-1:0]    level;
    logic [WIDTH-1:0]    duty_cycle;
    logic                update;
    logic [PHASE_W-1:0]  phase;
    logic                cfg_err;

    modport master (
        output enable, tick, min_level, max_level, step, hold_ticks,
        input  level, duty_cycle, update, phase, cfg_err
    );

    modport slave (
        input  enable, tick, min_level, max_level, step, hold_ticks,
        output level, duty_cycle, update, phase, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/fade_ramp_gamma.sv
`default_nettype none
// ============================================================================
// fade_gamma : registers duty from level, optionally squared (gamma ~2)
// Rev 1.0
// ============================================================================
module fade_gamma #(
    parameter int WIDTH = 8,
    parameter int GAMMA = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_level,
    input  wire logic             i_valid,
    output logic      [WIDTH-1:0] o_duty,
    output logic                  o_update
);
    logic [WIDTH-1:0] w_duty;
    logic [WIDTH-1:0] r_duty;
    logic             r_update;

    generate
        if (GAMMA != 0) begin : g_gamma
            logic [2*WIDTH-1:0] w_lvl;
            logic [2*WIDTH-1:0] w_lvl_p1;
            logic [2*WIDTH-1:0] w_prod;
            // level*(level+1) never exceeds 2*WIDTH bits, so no wider product is needed
            assign w_lvl    = {{WIDTH{1'b0}}, i_level};
            assign w_lvl_p1 = w_lvl + (2*WIDTH)'(1);
            assign w_prod   = w_lvl * w_lvl_p1;
            assign w_duty   = WIDTH'(w_prod >> WIDTH);
        end else begin : g_linear
            assign w_duty = i_level;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty   <= '0;
            r_update <= 1'b0;
        end else begin
            r_duty   <= w_duty;
            r_update <= i_valid;
        end
    end

    assign o_duty   = r_duty;
    assign o_update = r_update;
endmodule
`default_nettype wire

// File: rtl/fade_ramp.sv
`default_nettype none
// ============================================================================
// fade_ramp : tick-driven up/hold/down brightness envelope with gamma output
// Rev 1.0
// ============================================================================
module fade_ramp
    import fade_ramp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HOLD_W = 8,
    parameter int GAMMA  = 1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    fade_ramp_if.slave bus
);
    logic [PHASE_W-1:0] r_state;
    logic [WIDTH-1:0]   r_level;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_cfg_err;
    logic               r_lvl_chg;

    logic               w_valid;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_floor;
    logic [PHASE_W-1:0] w_state_nxt;
    logic [WIDTH-1:0]   w_level_nxt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic [WIDTH-1:0]   w_duty;
    logic               w_update;

    assign w_valid = (bus.min_level < bus.max_level) && (bus.step != '0);
    // one extra bit keeps the up-sum and the down-floor free of wrap-around
    assign w_sum   = {1'b0, r_level} + {1'b0, bus.step};
    assign w_floor = {1'b0, bus.min_level} + {1'b0, bus.step};

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_hold_nxt  = r_hold_cnt;
        if (!bus.enable || !w_valid) begin
            w_state_nxt = FADE_IDLE;
            w_level_nxt = bus.min_level;
            w_hold_nxt  = '0;
        end else if (bus.tick) begin
            case (r_state)
                FADE_IDLE: w_state_nxt = FADE_UP;
                FADE_UP: begin
                    if (w_sum >= {1'b0, bus.max_level}) begin
                        w_level_nxt = bus.max_level;
                        w_hold_nxt  = '0;
                        w_state_nxt = FADE_HOLD_HI;
                    end else begin
                        w_level_nxt = w_sum[WIDTH-1:0];
                    end
                end
                FADE_HOLD_HI, FADE_HOLD_LO: begin
                    if (r_hold_cnt == bus.hold_ticks) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = (r_state == FADE_HOLD_HI) ? FADE_DOWN : FADE_UP;
                    end else begin
                        w_hold_nxt  = r_hold_cnt + HOLD_W'(1);
                    end
                end
                FADE_DOWN: begin
                    if ({1'b0, r_level} <= w_floor) begin
                        w_level_nxt = bus.min_level;
                        w_hold_nxt  = '0;
                        w_state_nxt = FADE_HOLD_LO;
                    end else begin
                        w_level_nxt = r_level - bus.step;
                    end
                end
                default: w_state_nxt = FADE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FADE_IDLE;
            r_level    <= '0;
            r_hold_cnt <= '0;
            r_cfg_err  <= 1'b0;
            r_lvl_chg  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_level    <= w_level_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_cfg_err  <= !w_valid;
            r_lvl_chg  <= (w_level_nxt != r_level);
        end
    end

    fade_gamma #(
        .WIDTH (WIDTH),
        .GAMMA (GAMMA)
    ) u_gamma (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_level  (r_level),
        .i_valid  (r_lvl_chg),
        .o_duty   (w_duty),
        .o_update (w_update)
    );

    assign bus.level      = r_level;
    assign bus.duty_cycle = w_duty;
    assign bus.update     = w_update;
    assign bus.phase      = r_state;
    assign bus.cfg_err    = r_cfg_err;
endmodule
`default_nettype wire

// File: tb/tb_fade_ramp.sv
`default_nettype none
// ============================================================================
// tb_fade_ramp : directed and random checks of fade_ramp against a ramp model
// Rev 1.0
// ============================================================================
module tb_fade_ramp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct { int cyc; int duty; } exp_t;
    exp_t q[$];

    int m_ph = 0, m_lv = 0, m_hc = 0, m_err = 0;

    fade_ramp_if #(.WIDTH(8), .HOLD_W(8)) bus ();

    fade_ramp #(.WIDTH(8), .HOLD_W(8), .GAMMA(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: apply one clock of the envelope rules to the model state
    task automatic drive(input bit en, input bit tk, input int mn, input int mx,
                         input int st, input int hd);
        int  old;
        bit  valid;
        @(negedge clk);
        bus.enable     = en;
        bus.tick       = tk;
        bus.min_level  = mn[7:0];
        bus.max_level  = mx[7:0];
        bus.step       = st[7:0];
        bus.hold_ticks = hd[7:0];
        old   = m_lv;
        valid = (mn < mx) && (st != 0);
        m_err = valid ? 0 : 1;
        if (!en || !valid) begin
            m_ph = 0; m_lv = mn; m_hc = 0;
        end else if (tk) begin
            case (m_ph)
                0: m_ph = 1;
                1: if (m_lv + st >= mx) begin m_lv = mx; m_hc = 0; m_ph = 2; end
                   else m_lv = m_lv + st;
                2, 4: if (m_hc == hd) begin m_hc = 0; m_ph = (m_ph == 2) ? 3 : 1; end
                      else m_hc = (m_hc + 1) % 256;
                3: if (m_lv <= mn + st) begin m_lv = mn; m_hc = 0; m_ph = 4; end
                   else m_lv = m_lv - st;
                default: m_ph = 0;
            endcase
        end
        if (m_lv != old) q.push_back('{cyc + 2, (m_lv * (m_lv + 1)) / 256});
        @(posedge clk);
        #1;
        chk("level", int'(bus.level), m_lv);
        chk("phase", int'(bus.phase), m_ph);
        chk("cfg_err", int'(bus.cfg_err), m_err);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (bus.update) begin
                if (q.size() == 0) chk("spurious_update", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("update_cycle", cyc, e.cyc);
                    chk("duty", int'(bus.duty_cycle), e.duty);
                end
            end else if (q.size() != 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("missed_update", 0, 1);
            end
        end
    end

    initial begin
        int seq1[10] = '{0, 3, 6, 9, 10, 10, 7, 4, 1, 0};
        int ph1[10]  = '{1, 1, 1, 1, 2, 3, 3, 3, 3, 4};
        int seq2[9]  = '{0, 3, 6, 9, 10, 10, 10, 10, 7};
        int mn, mx, st, hd;
        bit en;

        bus.enable = 1'b0; bus.tick = 1'b0;
        bus.min_level = '0; bus.max_level = '0; bus.step = '0; bus.hold_ticks = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", int'(bus.level), 0);
        chk("rst_duty", int'(bus.duty_cycle), 0);
        chk("rst_update", int'(bus.update), 0);
        chk("rst_phase", int'(bus.phase), 0);
        chk("rst_cfg_err", int'(bus.cfg_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic triangle with no hold
        drive(1, 0, 0, 10, 3, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 10, 3, 0);
            chk("seq_level", int'(bus.level), seq1[i]);
            chk("seq_phase", int'(bus.phase), ph1[i]);
            drive(1, 0, 0, 10, 3, 0);
        end

        // Hold of 2 keeps max for 3 ticks after the clamp
        drive(0, 0, 0, 10, 3, 2);
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 0, 10, 3, 2);
            chk("hold_level", int'(bus.level), seq2[i]);
        end

        // Full-scale step through gamma
        drive(0, 0, 0, 255, 255, 0);
        drive(1, 1, 0, 255, 255, 0);
        drive(1, 1, 0, 255, 255, 0);
        chk("gamma_level", int'(bus.level), 255);
        chk("gamma_no_upd_yet", int'(bus.update), 0);
        drive(1, 0, 0, 255, 255, 0);
        chk("gamma_duty", int'(bus.duty_cycle), 255);
        chk("gamma_upd", int'(bus.update), 1);
        drive(1, 0, 0, 255, 255, 0);
        chk("gamma_upd_pulse", int'(bus.update), 0);

        // Invalid configurations, then recovery through IDLE
        drive(1, 1, 0, 10, 0, 0);
        chk("step0_err", int'(bus.cfg_err), 1);
        drive(1, 1, 50, 50, 3, 0);
        chk("eq_err", int'(bus.cfg_err), 1);
        chk("eq_level", int'(bus.level), 50);
        drive(1, 1, 20, 60, 5, 0);
        chk("resume_phase", int'(bus.phase), 1);

        // Enable dropped while descending at level 9
        drive(0, 0, 2, 16, 7, 0);
        for (int i = 0; i < 5; i++) drive(1, 1, 2, 16, 7, 0);
        chk("down_level", int'(bus.level), 9);
        chk("down_phase", int'(bus.phase), 3);
        drive(0, 1, 2, 16, 7, 0);
        chk("drop_level", int'(bus.level), 2);
        chk("drop_phase", int'(bus.phase), 0);
        drive(0, 1, 2, 16, 7, 0);

        // Asynchronous reset mid-ramp at level 6
        drive(0, 0, 0, 10, 3, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 10, 3, 0);
        chk("pre_rst_level", int'(bus.level), 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", int'(bus.level), 0);
        chk("arst_duty", int'(bus.duty_cycle), 0);
        chk("arst_update", int'(bus.update), 0);
        chk("arst_phase", int'(bus.phase), 0);
        q.delete();
        m_ph = 0; m_lv = 0; m_hc = 0; m_err = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random configurations, including mid-ramp bound changes
        mn = 0; mx = 100; st = 7; hd = 1; en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                mn = $urandom_range(0, 120);
                mx = $urandom_range(0, 255);
                st = $urandom_range(0, 40);
                hd = $urandom_range(0, 3);
                en = ($urandom_range(0, 9) != 0);
            end
            drive(en, ($urandom_range(0, 2) == 0), mn, mx, st, hd);
        end

        for (int i = 0; i < 4; i++) drive(0, 0, mn, mx, st, hd);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
